// File: rtl/seg7_scan_capture.sv
// Rebuilds 4 BCD digits from a scanned active-low 7-seg bus; SEG7CAP_SYNC2_EN selects a 2-flop input synchronizer.
// Latency: accept at edge N+D+STABLE_CYCLES after pins settle (D = 1 or 2); pulses are registered off that edge.
// Backpressure: none, passive observer; every output is a one-cycle pulse or a held frame register.
module seg7_scan_capture #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  an_n,
  output logic [15:0] bcd,
  output logic        frame_valid,
  output logic        pat_err,
  output logic        contention,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  localparam logic [7:0]  STABLE_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0]  STABLE_MAX  = 8'(STABLE_CYCLES);
  localparam logic [19:0] TMO_MAX     = 20'(TIMEOUT_CYCLES);

  logic [10:0] s;
  logic [10:0] s_prev;

`ifdef SEG7CAP_SYNC2_EN
  logic [10:0] s_meta;
  always_ff @(posedge clk) begin
    if (reset) begin
      s_meta <= '1;
      s      <= '1;
    end else begin
      s_meta <= {an_n, seg_n};
      s      <= s_meta;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) s <= '1;
    else       s <= {an_n, seg_n};
  end
`endif

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic [19:0] tcnt;
  logic [3:0]  mask;
  logic [15:0] digit_buf;
  logic        changed, any_low, multi_low, enter_held, accept, collide;
  logic [3:0]  an_low, mask_nxt, digit;
  logic [15:0] frame_dat;

  function automatic logic [3:0] decode(input logic [6:0] pat);
    case (pat)
      7'h40:   return 4'h0;
      7'h79:   return 4'h1;
      7'h24:   return 4'h2;
      7'h30:   return 4'h3;
      7'h19:   return 4'h4;
      7'h12:   return 4'h5;
      7'h02:   return 4'h6;
      7'h78:   return 4'h7;
      7'h00:   return 4'h8;
      7'h10:   return 4'h9;
      7'h7F:   return 4'hF;
      default: return 4'hE;
    endcase
  endfunction

  assign changed   = (s != s_prev);
  assign an_low    = ~s[10:7];
  assign any_low   = |an_low;
  assign multi_low = |(an_low & (an_low - 4'd1));
  assign digit     = decode(s[6:0]);
  assign mask_nxt  = mask | an_low;

  always_comb begin
    state_nxt  = state;
    enter_held = 1'b0;
    if (changed) begin
      state_nxt = any_low ? SETTLE : IDLE;
    end else if (state == SETTLE && cnt == STABLE_LAST) begin
      state_nxt  = HELD;
      enter_held = 1'b1;
    end
  end

  assign accept  = enter_held && any_low && !multi_low;
  assign collide = enter_held && multi_low;

  // Buffer with the newly accepted digit merged in, so a completing accept loads bcd in one edge.
  always_comb begin
    frame_dat = digit_buf;
    for (int i = 0; i < 4; i++) begin
      if (an_low[i]) frame_dat[4*i +: 4] = digit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_prev      <= '1;
      state       <= IDLE;
      cnt         <= '0;
      tcnt        <= '0;
      mask        <= '0;
      digit_buf   <= '1;
      bcd         <= 16'hFFFF;
      frame_valid <= 1'b0;
      pat_err     <= 1'b0;
      contention  <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      s_prev      <= s;
      state       <= state_nxt;
      frame_valid <= 1'b0;
      pat_err     <= 1'b0;
      contention  <= collide;
      timeout     <= 1'b0;

      if (changed)                cnt <= '0;
      else if (cnt != STABLE_MAX) cnt <= cnt + 8'd1;

      // An accept always beats a timeout on the same edge.
      if (accept) begin
        tcnt      <= '0;
        pat_err   <= (digit == 4'hE);
        digit_buf <= frame_dat;
        if (mask_nxt == 4'hF) begin
          bcd         <= frame_dat;
          frame_valid <= 1'b1;
          mask        <= '0;
        end else begin
          mask <= mask_nxt;
        end
      end else if (tcnt != TMO_MAX) begin
        tcnt <= tcnt + 20'd1;
      end else if (|mask) begin
        mask    <= '0;
        timeout <= 1'b1;
      end
    end
  end

endmodule
